seg7_scan: RTL

- Parametrised, self-timed multiplexer for N-digit common-anode seven-segment displays; the next generation of the board display driver.
- Owns its refresh prescaler and the one-hot anode rotation.
- Decodes hex nibbles to segments internally, with per-digit blanking and decimal point.
- Snapshots the digit inputs once per frame so a value changing mid-scan never tears.
- Sits between the CPU debug/IO registers and the board display pins.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_hex_decode.sv | 13 +
 rtl/seg7_scan.sv | 124 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: blank/idle patterns
// and the active-low hex glyph table in {g,f,e,d,c,b,a} order.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK        = 7'b1111111;
  localparam logic [6:0] SEG_IDLE_DEFAULT = 7'b1011111;

  localparam logic [6:0] HEXSEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEXSEG[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = hex_to_seg(nibble_i);
  end

endmodule

// File: rtl/seg7_scan.sv
// Self-timed N-digit common-anode display multiplexer with per-frame input
// snapshot, blanking, decimal points and a frame-complete pulse.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int         N_DIGITS = 4,
  parameter int         DIV      = 50000,
  parameter logic [6:0] SEG_IDLE = SEG_IDLE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*N_DIGITS-1:0]   digits_i,
  input  logic [N_DIGITS-1:0]     blank_i,
  input  logic [N_DIGITS-1:0]     dp_i,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CUR_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [CUR_W-1:0]    CUR_MAX = CUR_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_ONE  = N_DIGITS'(1);

  logic [CNT_W-1:0]      r_cnt;
  logic [CUR_W-1:0]      r_cur;
  logic                  r_lit;
  logic [4*N_DIGITS-1:0] r_snap_digits;
  logic [N_DIGITS-1:0]   r_snap_blank;
  logic [N_DIGITS-1:0]   r_snap_dp;
  logic [N_DIGITS-1:0]   r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic                  r_wrap_q;
  logic                  r_frame_done;

  logic             w_tick;
  logic             w_wrap;
  logic             w_load;
  logic [CUR_W-1:0] w_next_cur;
  logic [3:0]       w_nibble;
  logic             w_blank;
  logic             w_dp;
  logic [6:0]       w_hex_seg;

  assign w_tick = en && (r_cnt == CNT_MAX);
  assign w_wrap = r_lit && (r_cur == CUR_MAX);
  // Next slot is digit 0 on first lighting or on wrap; that is when we snapshot.
  assign w_load = w_tick && (!r_lit || w_wrap);

  always_comb begin
    w_next_cur = r_cur;
    if (!r_lit || (r_cur == CUR_MAX)) begin
      w_next_cur = '0;
    end else begin
      w_next_cur = r_cur + 1'b1;
    end
  end

  // Digit 0 of a fresh frame comes straight from the live inputs being captured.
  always_comb begin
    w_nibble = r_snap_digits[{w_next_cur, 2'b00} +: 4];
    w_blank  = r_snap_blank[w_next_cur];
    w_dp     = r_snap_dp[w_next_cur];
    if (w_load) begin
      w_nibble = digits_i[3:0];
      w_blank  = blank_i[0];
      w_dp     = dp_i[0];
    end
  end

  seg7_hex_decode u_hex_decode (
    .nibble_i (w_nibble),
    .seg_o    (w_hex_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_cur         <= '0;
      r_lit         <= 1'b0;
      r_snap_digits <= '0;
      r_snap_blank  <= '0;
      r_snap_dp     <= '0;
      r_an          <= '1;
      r_seg         <= SEG_IDLE;
      r_dp          <= 1'b1;
      r_wrap_q      <= 1'b0;
      r_frame_done  <= 1'b0;
    end else if (!en) begin
      r_lit        <= 1'b0;
      r_an         <= '1;
      r_seg        <= SEG_IDLE;
      r_dp         <= 1'b1;
      r_wrap_q     <= 1'b0;
      r_frame_done <= r_wrap_q;
    end else begin
      r_cnt        <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
      r_wrap_q     <= w_tick && w_wrap;
      r_frame_done <= r_wrap_q;
      if (w_tick) begin
        r_lit <= 1'b1;
        r_cur <= w_next_cur;
        if (w_load) begin
          r_snap_digits <= digits_i;
          r_snap_blank  <= blank_i;
          r_snap_dp     <= dp_i;
        end
        r_an  <= ~(AN_ONE << w_next_cur);
        r_seg <= w_blank ? SEG_BLANK : w_hex_seg;
        r_dp  <= w_blank ? 1'b1 : ~w_dp;
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule
